ssg_stereo_dac: RTL

Downstream stage of the SSG. It consumes the 8-bit CHANNEL_A/B/C outputs of two SSG instances (TurboSound pair) and mixes them into left/right PCM using ABC, ACB or mono panning. A click-free mute ramp scales the mix. The scaled PCM drives two first-order sigma-delta modulators that produce 1-bit outputs for the board's RC-filtered audio pins.

---
 rtl/ssg_stereo_dac.sv | 108 ++++++++++
 1 files changed

// File: rtl/ssg_stereo_dac.sv
// ssg_stereo_dac: mixes two SSGs' A/B/C channels to stereo PCM with a click-free mute ramp and 1-bit sigma-delta outputs
//   CLK, RESET_N (async, active-low), CE (sample strobe)
//   A0/B0/C0, A1/B1/C1 : 8-bit channel levels of SSG0/SSG1
//   STEREO : 00 ABC, 01 ACB, 1x mono     MUTE : 1 fade to silence, 0 fade to full
//   PCM_L/PCM_R : registered gained PCM  DAC_L/DAC_R : sigma-delta bitstreams
//   MUTED : ramp FSM is in its silent state
module ssg_stereo_dac #(
    parameter int RAMP_DIV = 256,
    parameter int PCM_W    = 10
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             CE,
    input  logic [7:0]       A0,
    input  logic [7:0]       B0,
    input  logic [7:0]       C0,
    input  logic [7:0]       A1,
    input  logic [7:0]       B1,
    input  logic [7:0]       C1,
    input  logic [1:0]       STEREO,
    input  logic             MUTE,
    output logic [PCM_W-1:0] PCM_L,
    output logic [PCM_W-1:0] PCM_R,
    output logic             DAC_L,
    output logic             DAC_R,
    output logic             MUTED
);
    localparam int CW = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
    typedef enum logic [1:0] {S_MUTED, S_FADE_IN, S_RUN, S_FADE_OUT} state_t;
    state_t            state_q, state_d;
    logic [4:0]        gain_q, gain_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              tick;
    logic [PCM_W-1:0]  pcm_l_q, pcm_l_d, pcm_r_q, pcm_r_d;
    logic [PCM_W:0]    acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic [PCM_W:0]    a0, b0, c0, a1, b1, c1, sum_all, hb, hc, mix_l, mix_r;
    always_comb begin
        a0      = {{(PCM_W-7){1'b0}}, A0};
        b0      = {{(PCM_W-7){1'b0}}, B0};
        c0      = {{(PCM_W-7){1'b0}}, C0};
        a1      = {{(PCM_W-7){1'b0}}, A1};
        b1      = {{(PCM_W-7){1'b0}}, B1};
        c1      = {{(PCM_W-7){1'b0}}, C1};
        sum_all = a0 + b0 + c0 + a1 + b1 + c1;
        // halving is per chip, so each half truncates on its own
        hb      = (b0 >> 1) + (b1 >> 1);
        hc      = (c0 >> 1) + (c1 >> 1);
        mix_l   = STEREO[1] ? sum_all >> 1 : STEREO[0] ? a0 + a1 + hc : a0 + a1 + hb;
        mix_r   = STEREO[1] ? sum_all >> 1 : STEREO[0] ? b0 + b1 + hc : c0 + c1 + hb;
        pcm_l_d = CE ? PCM_W'(({5'b0, mix_l} * {{(PCM_W+1){1'b0}}, gain_q}) >> 4) : pcm_l_q;
        pcm_r_d = CE ? PCM_W'(({5'b0, mix_r} * {{(PCM_W+1){1'b0}}, gain_q}) >> 4) : pcm_r_q;
        // first-order modulator: the carry out of the low bits is the output bit
        acc_l_d = {1'b0, acc_l_q[PCM_W-1:0]} + {1'b0, pcm_l_q};
        acc_r_d = {1'b0, acc_r_q[PCM_W-1:0]} + {1'b0, pcm_r_q};
    end
    assign tick  = CE && (cnt_q == CW'(RAMP_DIV - 1));
    assign cnt_d = !CE ? cnt_q : tick ? '0 : cnt_q + CW'(1);
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        if (CE) begin
            case (state_q)
                S_MUTED:   if (!MUTE) state_d = S_FADE_IN;
                S_FADE_IN: begin
                    if (MUTE) state_d = S_FADE_OUT;
                    else if (gain_q == 5'd16) state_d = S_RUN;
                    else if (tick) begin
                        gain_d = gain_q + 5'd1;
                        if (gain_q == 5'd15) state_d = S_RUN;
                    end
                end
                S_RUN:     if (MUTE) state_d = S_FADE_OUT;
                default: begin
                    if (!MUTE) state_d = S_FADE_IN;
                    else if (gain_q == 5'd0) state_d = S_MUTED;
                    else if (tick) begin
                        gain_d = gain_q - 5'd1;
                        if (gain_q == 5'd1) state_d = S_MUTED;
                    end
                end
            endcase
        end
    end
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_MUTED;
            gain_q  <= '0;
            cnt_q   <= '0;
            pcm_l_q <= '0;
            pcm_r_q <= '0;
            acc_l_q <= '0;
            acc_r_q <= '0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
            cnt_q   <= cnt_d;
            pcm_l_q <= pcm_l_d;
            pcm_r_q <= pcm_r_d;
            acc_l_q <= acc_l_d;
            acc_r_q <= acc_r_d;
        end
    end
    assign PCM_L = pcm_l_q;
    assign PCM_R = pcm_r_q;
    assign DAC_L = acc_l_q[PCM_W];
    assign DAC_R = acc_r_q[PCM_W];
    assign MUTED = state_q == S_MUTED;
endmodule
